axi_pcie_rx_cw_mwr_parser: RTL and testbench

Downstream consumer of the RX demultiplexer's completer-write (CW) AXI-Stream port. Parses each Memory Write TLP into a registered header record (address, length, byte enables, BAR) and a DW-realigned payload stream, so the AXI master write engine never touches raw TLP headers. Non-MWr and error-forwarded TLPs are consumed and dropped, with status pulses. The block handles 3DW and 4DW headers at 64-bit TRN/AXI width.

---
 rtl/axi_pcie_rx_cw_mwr_parser.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_axi_pcie_rx_cw_mwr_parser.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_pcie_rx_cw_mwr_parser.sv
// -----------------------------------------------------------------------------
// axi_pcie_rx_cw_mwr_parser
//
// Takes the completer-write AXI-Stream from the RX demux and turns each Memory
// Write TLP into two things:
//   * a registered header record (byte address, DW length, first/last BE, BAR)
//   * a payload stream realigned so the first payload DW sits in [63:32].
// Anything that is not a MWr, or is error-forwarded, is swallowed and reported
// on drop_pulse. A TLP whose tlast disagrees with its length field is reported
// on len_err_pulse.
//
// Handshake rule for every channel here (cw input, header record, payload
// output): a transfer happens on a rising clock edge where valid and ready are
// both high. A valid, once raised, holds its data steady until that transfer.
// A ready may depend on the other side's valid.
//
// Ports
//   com_iclk, com_sysrst_n          clock, asynchronous active-low reset
//   s_axis_cw_*                     TLP input, first DW of a beat in [63:32]
//                                   tuser[1] error-forward, tuser[8:2] BAR hit
//   hdr_valid/hdr_ready, hdr_*      header record channel
//   m_axis_wr_*                     payload output, one register stage
//   drop_pulse, len_err_pulse       one-cycle status pulses
//   dbg_state                       current parser state, for observation only
// -----------------------------------------------------------------------------
module axi_pcie_rx_cw_mwr_parser #(
  parameter int C_DATA_WIDTH = 64,
  parameter int TCQ          = 1
) (
  input  logic                      com_iclk,
  input  logic                      com_sysrst_n,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_cw_tdata,
  input  logic                      s_axis_cw_tvalid,
  output logic                      s_axis_cw_tready,
  input  logic [C_DATA_WIDTH/8-1:0] s_axis_cw_tstrb,
  input  logic                      s_axis_cw_tlast,
  input  logic [21:0]               s_axis_cw_tuser,
  output logic                      hdr_valid,
  input  logic                      hdr_ready,
  output logic [63:0]               hdr_addr,
  output logic [10:0]               hdr_len,
  output logic [3:0]                hdr_first_be,
  output logic [3:0]                hdr_last_be,
  output logic [6:0]                hdr_bar,
  output logic [C_DATA_WIDTH-1:0]   m_axis_wr_tdata,
  output logic                      m_axis_wr_tvalid,
  input  logic                      m_axis_wr_tready,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_wr_tstrb,
  output logic                      m_axis_wr_tlast,
  output logic                      drop_pulse,
  output logic                      len_err_pulse,
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    S_HDR0  = 3'd0,
    S_HDR1  = 3'd1,
    S_PAY   = 3'd2,
    S_FLUSH = 3'd3,
    S_DROP  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        running_q;       // low in the first cycle after reset release
  logic        is_4dw_q;
  logic        drop_done_q, drop_done_d;   // tlast already seen on a dropped beat 0
  logic        flush_drop_q, flush_drop_d; // after FLUSH, discard the rest of the TLP
  logic [10:0] dw_rem_q, dw_rem_d;         // input payload DWs still expected
  logic [31:0] dw_hold_q, dw_hold_d;       // 3DW: payload DW carried to the next beat

  logic        cw_ready, cw_fire, m_free;
  logic        cap0, cap1, hdr_set, pay_load, pay_last, len_err, drop;
  logic [63:0] pay_data;
  logic [7:0]  pay_strb;

  // Beat 0 decode: DW0 lives in [63:32].
  logic [1:0]  b0_fmt;
  logic [4:0]  b0_type;
  logic        b0_is_mwr;
  logic [10:0] b0_len;

  assign b0_fmt    = s_axis_cw_tdata[62:61];
  assign b0_type   = s_axis_cw_tdata[60:56];
  assign b0_is_mwr = b0_fmt[1] & (b0_type == 5'b00000);
  assign b0_len    = (s_axis_cw_tdata[41:32] == 10'd0) ? 11'd1024
                                                       : {1'b0, s_axis_cw_tdata[41:32]};

  logic unused_ok;
  assign unused_ok = &{1'b0, s_axis_cw_tstrb, s_axis_cw_tuser[21:9],
                       s_axis_cw_tuser[0], TCQ[0]};

  assign m_free    = !m_axis_wr_tvalid | m_axis_wr_tready;
  assign dbg_state = state_q;

  always_comb begin
    cw_ready = 1'b0;
    case (state_q)
      S_HDR0:  cw_ready = !hdr_valid | hdr_ready;
      S_HDR1:  cw_ready = 1'b1;
      S_PAY:   cw_ready = m_free;
      S_FLUSH: cw_ready = 1'b0;
      S_DROP:  cw_ready = !drop_done_q;
      default: cw_ready = 1'b0;
    endcase
  end

  assign s_axis_cw_tready = cw_ready & running_q;
  assign cw_fire          = s_axis_cw_tvalid & s_axis_cw_tready;

  always_comb begin
    state_d      = state_q;
    drop_done_d  = drop_done_q;
    flush_drop_d = flush_drop_q;
    dw_rem_d     = dw_rem_q;
    dw_hold_d    = dw_hold_q;
    cap0         = 1'b0;
    cap1         = 1'b0;
    hdr_set      = 1'b0;
    pay_load     = 1'b0;
    pay_data     = 64'h0;
    pay_strb     = 8'hFF;
    pay_last     = 1'b0;
    len_err      = 1'b0;
    drop         = 1'b0;

    case (state_q)
      S_HDR0: begin
        if (cw_fire) begin
          cap0 = 1'b1;
          if (!b0_is_mwr || s_axis_cw_tuser[1]) begin
            drop        = 1'b1;
            state_d     = S_DROP;
            drop_done_d = s_axis_cw_tlast;
          end else if (s_axis_cw_tlast) begin
            len_err = 1'b1;              // MWr with no address beat at all
          end else begin
            state_d = S_HDR1;
          end
        end
      end

      S_HDR1: begin
        if (cw_fire) begin
          cap1 = 1'b1;
          if (is_4dw_q) begin
            dw_rem_d = hdr_len;
            if (s_axis_cw_tlast) begin
              len_err = 1'b1;            // header only; no record is issued
              state_d = S_HDR0;
            end else begin
              hdr_set = 1'b1;
              state_d = S_PAY;
            end
          end else begin
            dw_rem_d  = hdr_len - 11'd1;
            dw_hold_d = s_axis_cw_tdata[31:0];
            hdr_set   = 1'b1;
            if (hdr_len == 11'd1) begin
              state_d      = S_FLUSH;
              flush_drop_d = !s_axis_cw_tlast;
              len_err      = !s_axis_cw_tlast;
            end else if (s_axis_cw_tlast) begin
              state_d      = S_FLUSH;
              flush_drop_d = 1'b0;
              len_err      = 1'b1;
            end else begin
              state_d = S_PAY;
            end
          end
        end
      end

      S_PAY: begin
        if (cw_fire) begin
          pay_load = 1'b1;
          dw_rem_d = dw_rem_q - 11'd2;
          if (is_4dw_q) begin
            pay_data = s_axis_cw_tdata;
            pay_strb = (dw_rem_q == 11'd1) ? 8'hF0 : 8'hFF;
            pay_last = (dw_rem_q <= 11'd2) | s_axis_cw_tlast;
            if (dw_rem_q <= 11'd2) begin
              state_d     = s_axis_cw_tlast ? S_HDR0 : S_DROP;
              len_err     = !s_axis_cw_tlast;
              drop_done_d = 1'b0;
            end else if (s_axis_cw_tlast) begin
              len_err = 1'b1;
              state_d = S_HDR0;
            end
          end else begin
            // 3DW: the held DW leads, the upper input DW completes the beat.
            pay_data  = {dw_hold_q, s_axis_cw_tdata[63:32]};
            dw_hold_d = s_axis_cw_tdata[31:0];
            if (dw_rem_q == 11'd1) begin
              pay_last    = 1'b1;
              state_d     = s_axis_cw_tlast ? S_HDR0 : S_DROP;
              len_err     = !s_axis_cw_tlast;
              drop_done_d = 1'b0;
            end else if (dw_rem_q == 11'd2) begin
              state_d      = S_FLUSH;
              flush_drop_d = !s_axis_cw_tlast;
              len_err      = !s_axis_cw_tlast;
            end else if (s_axis_cw_tlast) begin
              pay_last = 1'b1;
              len_err  = 1'b1;
              state_d  = S_HDR0;
            end
          end
        end
      end

      S_FLUSH: begin
        if (m_free) begin
          pay_load    = 1'b1;
          pay_data    = {dw_hold_q, 32'h0};
          pay_strb    = 8'hF0;
          pay_last    = 1'b1;
          drop_done_d = 1'b0;
          state_d     = flush_drop_q ? S_DROP : S_HDR0;
        end
      end

      S_DROP: begin
        if (drop_done_q) begin
          drop_done_d = 1'b0;
          state_d     = S_HDR0;
        end else if (cw_fire && s_axis_cw_tlast) begin
          state_d = S_HDR0;
        end
      end

      default: state_d = S_HDR0;
    endcase
  end

  always_ff @(posedge com_iclk or negedge com_sysrst_n) begin
    if (!com_sysrst_n) begin
      state_q      <= S_HDR0;
      running_q    <= 1'b0;
      is_4dw_q     <= 1'b0;
      drop_done_q  <= 1'b0;
      flush_drop_q <= 1'b0;
      dw_rem_q     <= 11'd0;
      dw_hold_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      running_q    <= 1'b1;
      drop_done_q  <= drop_done_d;
      flush_drop_q <= flush_drop_d;
      dw_rem_q     <= dw_rem_d;
      dw_hold_q    <= dw_hold_d;
      if (cap0) is_4dw_q <= b0_fmt[0];
    end
  end

  // Header record. Fields from beat 0 may be overwritten only once the
  // previous record has been taken, which the HDR0 ready term guarantees.
  always_ff @(posedge com_iclk or negedge com_sysrst_n) begin
    if (!com_sysrst_n) begin
      hdr_valid    <= 1'b0;
      hdr_addr     <= 64'h0;
      hdr_len      <= 11'd0;
      hdr_first_be <= 4'h0;
      hdr_last_be  <= 4'h0;
      hdr_bar      <= 7'h0;
    end else begin
      if (hdr_set)        hdr_valid <= 1'b1;
      else if (hdr_ready) hdr_valid <= 1'b0;
      if (cap0) begin
        hdr_len      <= b0_len;
        hdr_first_be <= s_axis_cw_tdata[3:0];
        hdr_last_be  <= s_axis_cw_tdata[7:4];
        hdr_bar      <= s_axis_cw_tuser[8:2];
      end
      if (cap1) begin
        if (is_4dw_q) hdr_addr <= {s_axis_cw_tdata[63:32], s_axis_cw_tdata[31:2], 2'b00};
        else          hdr_addr <= {32'h0, s_axis_cw_tdata[63:34], 2'b00};
      end
    end
  end

  always_ff @(posedge com_iclk or negedge com_sysrst_n) begin
    if (!com_sysrst_n) begin
      m_axis_wr_tvalid <= 1'b0;
      m_axis_wr_tdata  <= '0;
      m_axis_wr_tstrb  <= '0;
      m_axis_wr_tlast  <= 1'b0;
      drop_pulse       <= 1'b0;
      len_err_pulse    <= 1'b0;
    end else begin
      if (pay_load) begin
        m_axis_wr_tvalid <= 1'b1;
        m_axis_wr_tdata  <= pay_data;
        m_axis_wr_tstrb  <= pay_strb;
        m_axis_wr_tlast  <= pay_last;
      end else if (m_axis_wr_tready) begin
        m_axis_wr_tvalid <= 1'b0;
      end
      drop_pulse    <= drop;
      len_err_pulse <= len_err;
    end
  end

endmodule

// File: tb/tb_axi_pcie_rx_cw_mwr_parser.sv
// -----------------------------------------------------------------------------
// Bench for axi_pcie_rx_cw_mwr_parser. Inputs change 1 time unit after the
// rising edge; outputs and handshakes are sampled on the falling edge.
// Expected header records and payload beats are pushed when a TLP is built
// and popped when the DUT hands them over.
// -----------------------------------------------------------------------------
module tb_axi_pcie_rx_cw_mwr_parser;

  logic        com_iclk;
  logic        com_sysrst_n;
  logic [63:0] s_axis_cw_tdata;
  logic        s_axis_cw_tvalid;
  logic        s_axis_cw_tready;
  logic [7:0]  s_axis_cw_tstrb;
  logic        s_axis_cw_tlast;
  logic [21:0] s_axis_cw_tuser;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [63:0] hdr_addr;
  logic [10:0] hdr_len;
  logic [3:0]  hdr_first_be;
  logic [3:0]  hdr_last_be;
  logic [6:0]  hdr_bar;
  logic [63:0] m_axis_wr_tdata;
  logic        m_axis_wr_tvalid;
  logic        m_axis_wr_tready;
  logic [7:0]  m_axis_wr_tstrb;
  logic        m_axis_wr_tlast;
  logic        drop_pulse;
  logic        len_err_pulse;
  logic [2:0]  dbg_state;

  axi_pcie_rx_cw_mwr_parser #(.C_DATA_WIDTH(64), .TCQ(1)) dut (
    .com_iclk         (com_iclk),
    .com_sysrst_n     (com_sysrst_n),
    .s_axis_cw_tdata  (s_axis_cw_tdata),
    .s_axis_cw_tvalid (s_axis_cw_tvalid),
    .s_axis_cw_tready (s_axis_cw_tready),
    .s_axis_cw_tstrb  (s_axis_cw_tstrb),
    .s_axis_cw_tlast  (s_axis_cw_tlast),
    .s_axis_cw_tuser  (s_axis_cw_tuser),
    .hdr_valid        (hdr_valid),
    .hdr_ready        (hdr_ready),
    .hdr_addr         (hdr_addr),
    .hdr_len          (hdr_len),
    .hdr_first_be     (hdr_first_be),
    .hdr_last_be      (hdr_last_be),
    .hdr_bar          (hdr_bar),
    .m_axis_wr_tdata  (m_axis_wr_tdata),
    .m_axis_wr_tvalid (m_axis_wr_tvalid),
    .m_axis_wr_tready (m_axis_wr_tready),
    .m_axis_wr_tstrb  (m_axis_wr_tstrb),
    .m_axis_wr_tlast  (m_axis_wr_tlast),
    .drop_pulse       (drop_pulse),
    .len_err_pulse    (len_err_pulse),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial com_iclk = 1'b0;
  always #5 com_iclk = ~com_iclk;

  // ---------------- scoreboard state ----------------
  logic [72:0] exp_pay[$];   // {tdata, tstrb, tlast}
  logic [89:0] exp_hdr[$];   // {addr, len, first_be, last_be, bar}
  int checks = 0;
  int errors = 0;
  int drop_exp = 0, drop_seen = 0;
  int lerr_exp = 0, lerr_seen = 0;
  bit mon_en = 1'b1;
  bit bp_en = 1'b0;
  bit tv_rand = 1'b0;
  bit chk_tready = 1'b0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- output backpressure ----------------
  always @(posedge com_iclk) begin
    #1;
    if (bp_en) begin
      m_axis_wr_tready = ($urandom_range(0, 3) != 0);
      hdr_ready        = ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge com_iclk) begin
    if (com_sysrst_n && mon_en) begin
      if (m_axis_wr_tvalid && m_axis_wr_tready) begin
        if (exp_pay.size() == 0)
          check("pay_unexpected", {m_axis_wr_tdata, m_axis_wr_tstrb, m_axis_wr_tlast}, 96'h0);
        else
          check("pay_beat", {m_axis_wr_tdata, m_axis_wr_tstrb, m_axis_wr_tlast},
                exp_pay.pop_front());
      end
      if (hdr_valid && hdr_ready) begin
        if (exp_hdr.size() == 0)
          check("hdr_unexpected", {hdr_addr, hdr_len, hdr_first_be, hdr_last_be, hdr_bar}, 96'h0);
        else
          check("hdr_rec", {hdr_addr, hdr_len, hdr_first_be, hdr_last_be, hdr_bar},
                exp_hdr.pop_front());
      end
      if (drop_pulse)    drop_seen++;
      if (len_err_pulse) lerr_seen++;
      if (chk_tready)    check("cw_tready_high", s_axis_cw_tready, 1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [63:0] d, input logic [21:0] u, input logic l);
    int  n;
    bit  acc;
    if (tv_rand)
      while ($urandom_range(0, 2) == 0) begin
        s_axis_cw_tvalid = 1'b0;
        @(posedge com_iclk); #1;
      end
    s_axis_cw_tdata  = d;
    s_axis_cw_tuser  = u;
    s_axis_cw_tlast  = l;
    s_axis_cw_tstrb  = 8'hFF;
    s_axis_cw_tvalid = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 4000) begin
      @(negedge com_iclk);
      acc = s_axis_cw_tready;
      @(posedge com_iclk); #1;
      n++;
    end
    if (!acc) check("cw_accept_timeout", 0, 1);
  endtask

  // Builds one TLP, records what the parser should produce, then drives it.
  // ndw payload DWs are sent; ndw < len models an early tlast.
  task automatic send_tlp(input bit is4, input bit mwr, input bit err,
                          input logic [63:0] addr, input int len, input int ndw,
                          input logic [6:0] bar, input logic [7:0] be);
    logic [31:0] dws[$];
    logic [31:0] pl[$];
    logic [31:0] dw0, dw1, dw_hi, dw_lo;
    logic [10:0] len11;
    logic [63:0] addr_eff;
    logic [21:0] user;
    int nb;
    len11    = len[10:0];
    dw0      = {1'b0, mwr, is4, 5'b00000, 14'h0, len11[9:0]};
    dw1      = {16'hBEEF, 8'h5A, be};
    addr_eff = is4 ? {addr[63:2], 2'b00} : {32'h0, addr[31:2], 2'b00};
    dws.push_back(dw0);
    dws.push_back(dw1);
    if (is4) begin
      dws.push_back(addr_eff[63:32]);
      dws.push_back(addr_eff[31:0]);
    end else begin
      dws.push_back(addr_eff[31:0]);
    end
    for (int i = 0; i < ndw; i++) begin
      pl.push_back($urandom);
      dws.push_back(pl[i]);
    end
    if (mwr && !err) begin
      exp_hdr.push_back({addr_eff, len11, be[3:0], be[7:4], bar});
      for (int i = 0; i < pl.size(); i += 2) begin
        if (i + 1 < pl.size())
          exp_pay.push_back({pl[i], pl[i+1], 8'hFF, (i + 2 >= pl.size())});
        else
          exp_pay.push_back({pl[i], 32'h0, 8'hF0, 1'b1});
      end
      if (ndw < len) lerr_exp++;
    end else begin
      drop_exp++;
    end
    user = {13'h0, bar, err, 1'b0};
    nb = (dws.size() + 1) / 2;
    for (int b = 0; b < nb; b++) begin
      dw_hi = dws[2*b];
      dw_lo = (2*b + 1 < dws.size()) ? dws[2*b+1] : 32'h0;
      drive_beat({dw_hi, dw_lo}, user, (b == nb - 1));
    end
    s_axis_cw_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_pay.size() != 0 || exp_hdr.size() != 0) && n < 20000) begin
      @(posedge com_iclk);
      n++;
    end
    check({tag, "_drain"}, (n < 20000), 1);
    repeat (4) @(posedge com_iclk);
    #1;
    check({tag, "_drop_cnt"}, drop_seen, drop_exp);
    check({tag, "_lerr_cnt"}, lerr_seen, lerr_exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hdr_out"}, {hdr_valid, hdr_addr, hdr_len, hdr_first_be, hdr_last_be, hdr_bar}, 96'h0);
    check({tag, "_pay_out"}, {m_axis_wr_tvalid, m_axis_wr_tdata, m_axis_wr_tstrb, m_axis_wr_tlast}, 96'h0);
    check({tag, "_misc_out"}, {s_axis_cw_tready, drop_pulse, len_err_pulse, dbg_state}, 96'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] w0;
    logic [63:0] rnd_addr;
    int k, len;
    bit is4;
    com_sysrst_n     = 1'b0;
    s_axis_cw_tdata  = 64'h0;
    s_axis_cw_tvalid = 1'b0;
    s_axis_cw_tstrb  = 8'h0;
    s_axis_cw_tlast  = 1'b0;
    s_axis_cw_tuser  = 22'h0;
    hdr_ready        = 1'b1;
    m_axis_wr_tready = 1'b1;

    repeat (3) @(posedge com_iclk);
    @(negedge com_iclk);
    check_all_zero("reset");
    @(posedge com_iclk); #1;
    com_sysrst_n = 1'b1;
    repeat (2) @(posedge com_iclk); #1;

    // 4DW MWr, len 4
    send_tlp(1'b1, 1'b1, 1'b0, 64'h1_2345_6780, 4, 4, 7'h01, 8'hFF);
    wait_drain("mwr4_len4");

    // 3DW MWr, len 3: odd tail goes through FLUSH
    send_tlp(1'b0, 1'b1, 1'b0, 64'h1000, 3, 3, 7'h02, 8'hFF);
    wait_drain("mwr3_len3");

    // 3DW len 1 and len 1024 (length field 0)
    send_tlp(1'b0, 1'b1, 1'b0, 64'h2000, 1, 1, 7'h04, 8'h0F);
    send_tlp(1'b0, 1'b1, 1'b0, 64'h3000, 1024, 1024, 7'h08, 8'hFF);
    wait_drain("mwr3_len1_1024");

    // MRd and error-forwarded MWr: both dropped, tready stays high
    chk_tready = 1'b1;
    send_tlp(1'b0, 1'b0, 1'b0, 64'h4000, 2, 0, 7'h01, 8'hFF);
    send_tlp(1'b1, 1'b1, 1'b1, 64'h5_0000_4000, 4, 4, 7'h01, 8'hFF);
    chk_tready = 1'b0;
    wait_drain("drops");

    // len 8 cut short after 2 payload beats, then a clean TLP
    send_tlp(1'b1, 1'b1, 1'b0, 64'h6_0000_0100, 8, 4, 7'h10, 8'hFF);
    send_tlp(1'b0, 1'b1, 1'b0, 64'h7700, 5, 5, 7'h20, 8'hF3);
    wait_drain("trunc");

    // mixed traffic under random backpressure on every channel
    bp_en   = 1'b1;
    tv_rand = 1'b1;
    for (int t = 0; t < 200; t++) begin
      k        = $urandom_range(0, 9);
      is4      = ($urandom_range(0, 1) == 1);
      len      = $urandom_range(1, 20);
      rnd_addr = {$urandom, $urandom};
      if (k == 0)
        send_tlp(is4, 1'b0, 1'b0, rnd_addr, len, 0, 7'($urandom_range(0, 127)), 8'($urandom));
      else if (k == 1)
        send_tlp(is4, 1'b1, 1'b1, rnd_addr, len, len, 7'($urandom_range(0, 127)), 8'($urandom));
      else
        send_tlp(is4, 1'b1, 1'b0, rnd_addr, len, len, 7'($urandom_range(0, 127)), 8'($urandom));
    end
    wait_drain("random");
    bp_en            = 1'b0;
    tv_rand          = 1'b0;
    m_axis_wr_tready = 1'b1;
    hdr_ready        = 1'b1;
    @(posedge com_iclk); #1;

    // reset in the middle of a payload, outputs stalled
    mon_en           = 1'b0;
    m_axis_wr_tready = 1'b0;
    hdr_ready        = 1'b0;
    w0 = {1'b0, 2'b11, 5'b00000, 14'h0, 10'd8, 16'hBEEF, 8'h01, 8'hFF};
    drive_beat(w0, 22'h0, 1'b0);
    drive_beat(64'h0000_0000_8000_0000, 22'h0, 1'b0);
    drive_beat({$urandom, $urandom}, 22'h0, 1'b0);
    s_axis_cw_tdata = {$urandom, $urandom};
    com_sysrst_n    = 1'b0;
    @(negedge com_iclk);
    check_all_zero("mid_reset");
    s_axis_cw_tvalid = 1'b0;
    repeat (2) @(posedge com_iclk); #1;
    com_sysrst_n     = 1'b1;
    mon_en           = 1'b1;
    m_axis_wr_tready = 1'b1;
    hdr_ready        = 1'b1;
    repeat (2) @(posedge com_iclk); #1;
    send_tlp(1'b0, 1'b1, 1'b0, 64'h8800, 5, 5, 7'h05, 8'hFF);
    wait_drain("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
